// File: rtl/pipe_adder_pkg.sv
// Shared constants and elaboration helpers for pipelined_segment_adder.
// Optional overflow output is enabled by defining PIPE_ADDER_OVF_EN.
package pipe_adder_pkg;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_SEG   = 16;

   function automatic bit legal(input int w, input int s);
      return (s >= 1) && (w >= s) && ((w % s) == 0);
   endfunction

   function automatic int stages(input int w, input int s);
      return (s < 1) ? 1 : w / s;
   endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit add slice used once per pipeline stage.
// Overflow build (PIPE_ADDER_OVF_EN) derives MSB carry-in in the top.
module adder_segment
   import pipe_adder_pkg::*;
#(
   parameter int SEG = DEF_SEG
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] s,
   output logic           cout
);

   logic [SEG:0] t;

   assign t    = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
   assign s    = t[SEG-1:0];
   assign cout = t[SEG];

endmodule

// File: rtl/pipelined_segment_adder.sv
// Segment-pipelined add/sub with skew/de-skew chains and global stall.
// Define PIPE_ADDER_OVF_EN to build the signed-overflow output.
module pipelined_segment_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEG   = DEF_SEG
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int STAGES = stages(WIDTH, SEG);

   if (!legal(WIDTH, SEG)) begin : g_bad
      $error("WIDTH must be a multiple of SEG, SEG >= 1");
   end

   logic             adv;
   logic [WIDTH-1:0] b_in;
   logic             cin0;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign b_in     = in_sub ? ~in_b : in_b;
   assign cin0     = in_sub | in_cin;

   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int HI = WIDTH - (k + 1) * SEG;

      logic [SEG-1:0]         a_s, b_s, s_s;
      logic                   c_s, co_s, v_s;
      logic                   v_q, c_q;
      logic [(k+1)*SEG-1:0]   lo_q, lo_d;

      if (k == 0) begin : g_src
         assign a_s  = in_a[SEG-1:0];
         assign b_s  = b_in[SEG-1:0];
         assign c_s  = cin0;
         assign v_s  = in_valid;
         assign lo_d = s_s;
      end else begin : g_src
         assign a_s  = stg[k-1].g_hi.ah_q[SEG-1:0];
         assign b_s  = stg[k-1].g_hi.bh_q[SEG-1:0];
         assign c_s  = stg[k-1].c_q;
         assign v_s  = stg[k-1].v_q;
         assign lo_d = {s_s, stg[k-1].lo_q};
      end

      adder_segment #(.SEG(SEG)) u_seg (
         .a    (a_s),
         .b    (b_s),
         .cin  (c_s),
         .s    (s_s),
         .cout (co_s)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q  <= 1'b0;
            c_q  <= 1'b0;
            lo_q <= '0;
         end else if (adv) begin
            v_q  <= v_s;
            c_q  <= co_s;
            lo_q <= lo_d;
         end
      end

      // Operand segments not yet consumed ride along with the beat
      if (k < STAGES - 1) begin : g_hi
         logic [HI-1:0] ah_q, bh_q, ah_d, bh_d;

         if (k == 0) begin : g_s0
            assign ah_d = in_a[WIDTH-1:SEG];
            assign bh_d = b_in[WIDTH-1:SEG];
         end else begin : g_sn
            assign ah_d = stg[k-1].g_hi.ah_q[HI+SEG-1:SEG];
            assign bh_d = stg[k-1].g_hi.bh_q[HI+SEG-1:SEG];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ah_q <= '0;
               bh_q <= '0;
            end else if (adv) begin
               ah_q <= ah_d;
               bh_q <= bh_d;
            end
         end
      end

`ifdef PIPE_ADDER_OVF_EN
      if (k == STAGES - 1) begin : g_ovf
         logic o_q, o_d;

         // carry into MSB is recovered as a ^ b ^ sum at that bit
         assign o_d = a_s[SEG-1] ^ b_s[SEG-1] ^ s_s[SEG-1] ^ co_s;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               o_q <= 1'b0;
            end else if (adv) begin
               o_q <= o_d;
            end
         end
      end
`endif
   end

   assign out_valid = stg[STAGES-1].v_q;
   assign out_sum   = stg[STAGES-1].lo_q;
   assign out_cout  = stg[STAGES-1].c_q;

`ifdef PIPE_ADDER_OVF_EN
   assign out_ovf = stg[STAGES-1].g_ovf.o_q;
`else
   assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Self-checking bench: vector table, random streams, backpressure, reset.
// Expected overflow follows PIPE_ADDER_OVF_EN.
module tb_pipelined_segment_adder;

`ifdef PIPE_ADDER_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif
   localparam int ST = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_cin, in_sub;
   logic [63:0] in_a, in_b;
   logic        out_valid, out_ready, out_cout, out_ovf;
   logic [63:0] out_sum;

   logic        n_valid, n_ready, n_cin, n_sub;
   logic [7:0]  n_a, n_b, n_sum;
   logic        n_ovalid, n_oready, n_cout, n_ovf;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipelined_segment_adder #(.WIDTH(64), .SEG(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
   );

   pipelined_segment_adder #(.WIDTH(8), .SEG(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(n_valid), .in_ready(n_ready),
      .in_a(n_a), .in_b(n_b), .in_cin(n_cin), .in_sub(n_sub),
      .out_valid(n_ovalid), .out_ready(n_oready),
      .out_sum(n_sum), .out_cout(n_cout), .out_ovf(n_ovf)
   );

   typedef struct {
      logic [63:0] a, b;
      logic        cin, sub;
      logic [63:0] es;
      logic        ec, eo;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Spec-level arithmetic: unsigned result, borrow test, signed range
   function automatic logic [65:0] model(input logic [63:0] a, b,
                                         input logic cin, sub);
      logic signed [66:0] sr;
      logic [64:0]        u;
      logic [63:0]        s;
      logic               co, ov;
      if (sub) begin
         s  = a - b;
         co = (a >= b);
         sr = $signed({{3{a[63]}}, a}) - $signed({{3{b[63]}}, b});
      end else begin
         u  = {1'b0, a} + {1'b0, b} + {64'd0, cin};
         s  = u[63:0];
         co = u[64];
         sr = $signed({{3{a[63]}}, a}) + $signed({{3{b[63]}}, b})
            + $signed({66'd0, cin});
      end
      ov = (sr[66:63] != {4{sr[63]}});
      return {ov & OVF_EN, co, s};
   endfunction

   function automatic logic [63:0] rnd64();
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(7))
         0: r = 64'hFFFF_FFFF_FFFF_FFFF;
         1: r = 64'h8000_0000_0000_0000;
         2: r = 64'h7FFF_FFFF_FFFF_FFFF;
         default: ;
      endcase
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      int cnt;
      in_valid = 1'b1;
      in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", idx), 64'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      cnt = 1;
      while (!out_valid && cnt < 20) begin
         tick();
         cnt++;
      end
      chk($sformatf("v%0d_latency", idx), 64'(cnt), ST);
      chk($sformatf("v%0d_sum", idx), out_sum, v.es);
      chk($sformatf("v%0d_cout", idx), 64'(out_cout), 64'(v.ec));
      chk($sformatf("v%0d_ovf", idx), 64'(out_ovf), 64'(v.eo & OVF_EN));
      tick();
   endtask

   task automatic new_beat(input int sent, input int n, input int vpct);
      if (sent < n && $urandom_range(99) < vpct) begin
         in_valid = 1'b1;
         in_a = rnd64(); in_b = rnd64();
         in_cin = 1'($urandom); in_sub = 1'($urandom);
      end else begin
         in_valid = 1'b0;
      end
   endtask

   task automatic run_stream(input int n, input int vpct, input int rpct,
                             input bit timing, input string tag);
      logic [65:0] q[$];
      logic [65:0] e;
      logic [63:0] hsum;
      int sent = 0, got = 0, budget = 0;
      int c_acc0 = -1, c_first = -1, c_last = -1;
      bit hold = 0, fire;
      new_beat(sent, n, vpct);
      out_ready = ($urandom_range(99) < rpct);
      while (got < n && budget < 4000) begin
         @(negedge clk);
         if (hold) begin
            chk({tag, "_hold_valid"}, 64'(out_valid), 1);
            chk({tag, "_hold_sum"}, out_sum, hsum);
         end
         if (out_valid && out_ready) begin
            chk({tag, "_no_dup"}, 64'(q.size() != 0), 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk({tag, "_sum"}, out_sum, e[63:0]);
               chk({tag, "_cout"}, 64'(out_cout), 64'(e[64]));
               chk({tag, "_ovf"}, 64'(out_ovf), 64'(e[65]));
            end
            got++;
            if (c_first < 0) c_first = cyc;
            c_last = cyc;
         end
         hold = out_valid && !out_ready;
         hsum = out_sum;
         fire = in_valid && in_ready;
         if (fire) begin
            q.push_back(model(in_a, in_b, in_cin, in_sub));
            sent++;
            if (c_acc0 < 0) c_acc0 = cyc;
         end
         tick();
         budget++;
         if (fire || !in_valid) new_beat(sent, n, vpct);
         out_ready = ($urandom_range(99) < rpct);
      end
      in_valid = 1'b0;
      chk({tag, "_count"}, 64'(got), 64'(n));
      chk({tag, "_drained"}, 64'(q.size()), 0);
      if (timing) begin
         chk({tag, "_first_lat"}, 64'(c_first - c_acc0), ST);
         chk({tag, "_spacing"}, 64'(c_last - c_first), 64'(n - 1));
      end
   endtask

   initial begin
      vec_t vt[8];
      int   stale;
      vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
      vt[1] = '{64'd5, 64'd7, 1'b0, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vt[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vt[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vt[4] = '{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0};
      vt[5] = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0};
      vt[6] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                64'h0000_0001_0000_0000, 1'b0, 1'b0};
      vt[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                1'b0, 1'b0, 64'd0, 1'b1, 1'b1};

      rst_n = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      out_ready = 1'b1;
      n_valid = 1'b0; n_a = 8'h7F; n_b = 8'h01; n_cin = 1'b0; n_sub = 1'b0;
      n_oready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_cout", 64'(out_cout), 0);
      chk("rst_out_ovf", 64'(out_ovf), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_n8_valid", 64'(n_ovalid), 0);
      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) apply_vec(vt[i], i);

      n_valid = 1'b1;
      tick();
      n_valid = 1'b0;
      chk("w8_latency1", 64'(n_ovalid), 1);
      chk("w8_sum", 64'(n_sum), 64'h80);
      chk("w8_cout", 64'(n_cout), 0);
      chk("w8_ovf", 64'(n_ovf), 64'(OVF_EN));
      tick();
      chk("w8_drained", 64'(n_ovalid), 0);

      run_stream(32, 100, 100, 1'b1, "stream");
      repeat (6) tick();
      run_stream(100, 80, 50, 1'b0, "bp");
      repeat (6) tick();

      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_a = rnd64(); in_b = rnd64(); in_cin = 1'b0; in_sub = 1'b0;
         tick();
      end
      in_valid = 1'b0;
      chk("fill_out_valid", 64'(out_valid), 1);
      chk("fill_in_ready", 64'(in_ready), 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 0);
      chk("arst_out_sum", out_sum, 0);
      chk("arst_out_cout", 64'(out_cout), 0);
      chk("arst_in_ready", 64'(in_ready), 1);
      repeat (2) tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      chk("arst_no_stale", 64'(stale), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
